// File: rtl/riscv_pkg.sv
// Shared encodings for the pipeline: memory-op codes, MEM-stage FSM states
// and the default datapath width.
package riscv_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_WRITE = 2'b01;
  localparam logic [1:0] MEM_READ  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/dmem_req_fsm.sv
// Data-cache request sequencer: tracks IDLE/BUSY/DONE, drives the cache
// request lines and the hold request to EX, and tells the top when to load.
module dmem_req_fsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mem_op,
  input  logic       cache_stall,
  output logic       ren,
  output logic       wen,
  output logic       memory_stall,
  output logic       capture,
  output logic       wb_load,
  output logic       use_buf
);

  mem_state_t state;
  logic       has_op;
  logic       requesting;

  assign has_op = (mem_op != MEM_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (has_op) state <= BUSY;
        BUSY:    if (!cache_stall) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so the request and hold drop the instant reset asserts,
  // even though EX may still be presenting a memory op.
  assign requesting   = rst_n && ((state == IDLE && has_op) || state == BUSY);
  assign memory_stall = requesting;
  assign ren          = requesting && (mem_op == MEM_READ);
  assign wen          = requesting && mem_op[0];

  assign capture = (state == BUSY) && !cache_stall;
  assign wb_load = (state == IDLE && !has_op) || (state == DONE);
  assign use_buf = (state == DONE) && (mem_op == MEM_READ);

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline stage 4 (MEM): issues data-cache accesses, holds EX while a
// memory op is in flight, and owns the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int DATA_W = riscv_pkg::DATA_W,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WriteBack_3,
  input  logic [1:0]        Mem_3,
  input  logic [DATA_W-1:0] ALU_result_3,
  input  logic [DATA_W-1:0] writedata_3,
  input  logic [4:0]        Rd_3,
  input  logic              DCACHE_stall,
  input  logic [DATA_W-1:0] DCACHE_rdata,
  output logic              DCACHE_ren,
  output logic              DCACHE_wen,
  output logic [ADDR_W-1:0] DCACHE_addr,
  output logic [DATA_W-1:0] DCACHE_wdata,
  output logic              memory_stall,
  output logic              WriteBack_4,
  output logic [4:0]        Rd_4,
  output logic [DATA_W-1:0] writeback_data_4
);

  import riscv_pkg::*;

  logic              capture;
  logic              wb_load;
  logic              use_buf;
  logic [DATA_W-1:0] load_buf;

  dmem_req_fsm u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_op       (Mem_3),
    .cache_stall  (DCACHE_stall),
    .ren          (DCACHE_ren),
    .wen          (DCACHE_wen),
    .memory_stall (memory_stall),
    .capture      (capture),
    .wb_load      (wb_load),
    .use_buf      (use_buf)
  );

  // Word access only: the byte offset bits never reach the cache.
  assign DCACHE_addr  = ALU_result_3[ADDR_W+1:2];
  assign DCACHE_wdata = writedata_3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_buf <= '0;
    end else if (capture) begin
      load_buf <= DCACHE_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WriteBack_4      <= 1'b0;
      Rd_4             <= '0;
      writeback_data_4 <= '0;
    end else if (wb_load) begin
      WriteBack_4      <= WriteBack_3;
      Rd_4             <= Rd_3;
      writeback_data_4 <= use_buf ? load_buf : ALU_result_3;
    end
  end

endmodule
